// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the single-issue RISC-V core. Owns the program
// counter, issues one word request at a time to instruction memory, and holds
// the returned instruction plus its address in an output register for decode.
// Downstream redirects (taken branches/jumps) override sequential fetch. A
// fetch that was already in flight when the redirect arrived is dropped when
// its response comes back.
//
// Ports:
//   clk            in   core clock, rising edge
//   rst            in   asynchronous active-high reset
//   imem_req       out  one-cycle request pulse to instruction memory
//   imem_addr      out  request address (word aligned, equals the PC register)
//   imem_rvalid    in   response valid (only honoured while waiting)
//   imem_rdata     in   response instruction word
//   redirect_i     in   taken branch/jump, highest priority
//   redirect_pc_i  in   redirect target (low two bits are ignored)
//   instr_o        out  held instruction for decode / immediate generator
//   pc_o           out  address of instr_o
//   valid_o        out  instr_o/pc_o hold a live instruction
//   ready_i        in   decode accepts instr_o this cycle
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter int unsigned                DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req,
  output logic [ADDRESS_WIDTH-1:0]  imem_addr,
  input  logic                      imem_rvalid,
  input  logic [DATA_WIDTH-1:0]     imem_rdata,
  input  logic                      redirect_i,
  input  logic [ADDRESS_WIDTH-1:0]  redirect_pc_i,
  output logic [DATA_WIDTH-1:0]     instr_o,
  output logic [ADDRESS_WIDTH-1:0]  pc_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK       = ~(ADDRESS_WIDTH'(2'b11));
  localparam logic [ADDRESS_WIDTH-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP          = ADDRESS_WIDTH'(3'd4);
  localparam logic [DATA_WIDTH-1:0]    NOP_INSTR        = DATA_WIDTH'(32'h0000_0013);

  state_t                     r_state;
  logic [ADDRESS_WIDTH-1:0]   r_pc;      // address of the next (or in-flight) fetch
  logic                       r_drop;    // in-flight response belongs to a squashed path
  logic [DATA_WIDTH-1:0]      r_instr;
  logic [ADDRESS_WIDTH-1:0]   r_pc_out;
  logic                       r_valid;

  logic                       w_req;
  logic [ADDRESS_WIDTH-1:0]   w_redirect_pc;

  // Redirect targets are forced onto a word boundary.
  assign w_redirect_pc = redirect_pc_i & ALIGN_MASK;

  // Request pulse: a new fetch starts from IDLE, or from FULL when decode
  // consumes the held word. A redirect always suppresses the request so the
  // stale PC is never fetched; nothing is issued while reset is held.
  always_comb begin
    w_req = 1'b0;
    if (rst || redirect_i) begin
      w_req = 1'b0;
    end else begin
      case (r_state)
        IDLE:    w_req = 1'b1;
        FULL:    w_req = ready_i;
        WAIT:    w_req = 1'b0;
        default: w_req = 1'b0;
      endcase
    end
  end

  // Fetch state machine, PC register and decode-facing output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC_ALIGNED;
      r_drop   <= 1'b0;
      r_instr  <= NOP_INSTR;
      r_pc_out <= RESET_PC_ALIGNED;
      r_valid  <= 1'b0;
    end else if (redirect_i) begin
      r_pc    <= w_redirect_pc;
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state <= IDLE;
        end
        WAIT: begin
          if (imem_rvalid) begin
            // The response arriving now is stale whatever r_drop says.
            r_state <= IDLE;
            r_drop  <= 1'b0;
          end else begin
            // Response still outstanding: mark it for discard on arrival.
            r_state <= WAIT;
            r_drop  <= 1'b1;
          end
        end
        FULL: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_drop  <= 1'b0;
        end
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_instr  <= imem_rdata;
              r_pc_out <= r_pc;
              r_valid  <= 1'b1;
              r_pc     <= r_pc + PC_STEP;   // wraps modulo 2^ADDRESS_WIDTH
              r_state  <= FULL;
            end
          end else begin
            r_state <= WAIT;
          end
        end
        FULL: begin
          if (ready_i) begin
            // Held word handed off; the next request went out this cycle.
            r_valid <= 1'b0;
            r_state <= WAIT;
          end else begin
            r_state <= FULL;
          end
        end
        default: begin
          r_state <= IDLE;
          r_drop  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign instr_o   = r_instr;
  assign pc_o      = r_pc_out;
  assign valid_o   = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ready_i;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_instr_o;
  logic [31:0] w_pc_o;
  logic        w_valid_o;

  int checks;
  int failures;

  fetch_stage #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i)
  );

  // Second instance starting just below the top of the address space.
  fetch_stage #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (w_imem_req),
    .imem_addr     (w_imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_o       (w_instr_o),
    .pc_o          (w_pc_o),
    .valid_o       (w_valid_o),
    .ready_i       (ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0000_0000;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0000_0000;
    ready_i       = 1'b1;

    // Reset values
    #2 rst = 1'b1;
    #1;
    chk("rst_valid",      {31'd0, valid_o},    32'd0);
    chk("rst_instr",      instr_o,             32'h0000_0013);
    chk("rst_pc",         pc_o,                32'h0000_0000);
    chk("rst_req",        {31'd0, imem_req},   32'd0);
    chk("rst_wrap_pc",    w_pc_o,              32'hFFFF_FFFC);
    chk("rst_wrap_req",   {31'd0, w_imem_req}, 32'd0);
    cyc();
    cyc();

    // Release reset: IDLE issues the first request at RESET_PC
    rst = 1'b0;
    #1;
    chk("first_req",       {31'd0, imem_req}, 32'd1);
    chk("first_addr",      imem_addr,         32'h0000_0000);
    chk("first_wrap_addr", w_imem_addr,       32'hFFFF_FFFC);
    cyc();

    // WAIT: 1-cycle memory answers now
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    #1;
    chk("wait_req",   {31'd0, imem_req}, 32'd0);
    chk("wait_valid", {31'd0, valid_o},  32'd0);
    cyc();

    // FULL with back-pressure
    imem_rvalid = 1'b0;
    ready_i     = 1'b0;
    #1;
    chk("full_valid",     {31'd0, valid_o},  32'd1);
    chk("full_instr",     instr_o,           32'h0050_0093);
    chk("full_pc",        pc_o,              32'h0000_0000);
    chk("full_bp_req",    {31'd0, imem_req}, 32'd0);
    chk("full_next_addr", imem_addr,         32'h0000_0004);
    chk("wrap_pc",        w_pc_o,            32'hFFFF_FFFC);
    chk("wrap_next_addr", w_imem_addr,       32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_valid", {31'd0, valid_o},  32'd1);
      chk("bp_instr", instr_o,           32'h0050_0093);
      chk("bp_pc",    pc_o,              32'h0000_0000);
      chk("bp_req",   {31'd0, imem_req}, 32'd0);
    end
    cyc();

    // Decode accepts: next request at pc_o+4 in the same cycle
    ready_i = 1'b1;
    #1;
    chk("accept_req",  {31'd0, imem_req}, 32'd1);
    chk("accept_addr", imem_addr,         32'h0000_0004);
    cyc();

    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A0_0113;
    #1;
    chk("acc_wait_valid", {31'd0, valid_o}, 32'd0);
    chk("acc_wait_req",   {31'd0, imem_req}, 32'd0);
    cyc();

    imem_rvalid = 1'b0;
    #1;
    chk("second_valid", {31'd0, valid_o},  32'd1);
    chk("second_instr", instr_o,           32'h00A0_0113);
    chk("second_pc",    pc_o,              32'h0000_0004);
    chk("second_req",   {31'd0, imem_req}, 32'd1);
    chk("second_addr",  imem_addr,         32'h0000_0008);
    cyc();

    // Redirect one cycle after the request to 0x8 (3-cycle memory)
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    #1;
    chk("redir_wait_req", {31'd0, imem_req}, 32'd0);
    cyc();
    redirect_i = 1'b0;
    #1;
    chk("drop_pend_valid", {31'd0, valid_o},  32'd0);
    chk("drop_pend_req",   {31'd0, imem_req}, 32'd0);
    cyc();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("drop_resp_req", {31'd0, imem_req}, 32'd0);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    chk("dropped_valid", {31'd0, valid_o},  32'd0);
    chk("dropped_instr", instr_o,           32'h00A0_0113);
    chk("redir_req",     {31'd0, imem_req}, 32'd1);
    chk("redir_addr",    imem_addr,         32'h0000_0100);
    cyc();

    // Redirect coinciding with the response
    imem_rvalid   = 1'b1;
    imem_rdata    = 32'h1111_1111;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0300;
    #1;
    chk("coinc_req", {31'd0, imem_req}, 32'd0);
    cyc();
    imem_rvalid = 1'b0;
    redirect_i  = 1'b0;
    #1;
    chk("coinc_valid", {31'd0, valid_o},  32'd0);
    chk("coinc_instr", instr_o,           32'h00A0_0113);
    chk("coinc_req2",  {31'd0, imem_req}, 32'd1);
    chk("coinc_addr",  imem_addr,         32'h0000_0300);
    cyc();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00C0_0193;
    cyc();

    // Redirect in FULL with ready_i=1 and an unaligned target
    imem_rvalid   = 1'b0;
    ready_i       = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0203;
    #1;
    chk("tgt_valid",     {31'd0, valid_o},  32'd1);
    chk("tgt_instr",     instr_o,           32'h00C0_0193);
    chk("tgt_pc",        pc_o,              32'h0000_0300);
    chk("full_redir_req", {31'd0, imem_req}, 32'd0);
    cyc();
    redirect_i = 1'b0;
    #1;
    chk("full_redir_valid", {31'd0, valid_o},  32'd0);
    chk("full_redir_req2",  {31'd0, imem_req}, 32'd1);
    chk("full_redir_addr",  imem_addr,         32'h0000_0200);
    cyc();

    // Reset during WAIT acts immediately
    rst = 1'b1;
    #1;
    chk("midrst_valid",   {31'd0, valid_o},  32'd0);
    chk("midrst_instr",   instr_o,           32'h0000_0013);
    chk("midrst_pc",      pc_o,              32'h0000_0000);
    chk("midrst_req",     {31'd0, imem_req}, 32'd0);
    chk("midrst_addr",    imem_addr,         32'h0000_0000);
    chk("midrst_wrap_pc", w_pc_o,            32'hFFFF_FFFC);
    cyc();

    // Late response right after release is ignored in IDLE
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    #1;
    chk("post_rst_req",       {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr",      imem_addr,         32'h0000_0000);
    chk("post_rst_wrap_addr", w_imem_addr,       32'hFFFF_FFFC);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    chk("late_valid", {31'd0, valid_o},  32'd0);
    chk("late_instr", instr_o,           32'h0000_0013);
    chk("late_req",   {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0010_0073;
    cyc();
    imem_rvalid = 1'b0;
    #1;
    chk("post_valid",     {31'd0, valid_o}, 32'd1);
    chk("post_instr",     instr_o,          32'h0010_0073);
    chk("post_pc",        pc_o,             32'h0000_0000);
    chk("post_addr",      imem_addr,        32'h0000_0004);
    chk("post_wrap_pc",   w_pc_o,           32'hFFFF_FFFC);
    chk("post_wrap_addr", w_imem_addr,      32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
